// File: rtl/rx_cmd_seq_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, FSM state
// encoding and the fixed register-file addresses of the ALU operands.
package rx_cmd_seq_pkg;

  localparam logic [7:0] OPC_WR  = 8'hAA;
  localparam logic [7:0] OPC_RD  = 8'hBB;
  localparam logic [7:0] OPC_ALU = 8'hCC;
  localparam logic [7:0] OPC_FUN = 8'hDD;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WR_ADDR   = 4'd1;
  localparam logic [3:0] ST_WR_DATA   = 4'd2;
  localparam logic [3:0] ST_RD_ADDR   = 4'd3;
  localparam logic [3:0] ST_RD_ISSUE  = 4'd4;
  localparam logic [3:0] ST_OP_A      = 4'd5;
  localparam logic [3:0] ST_OP_B      = 4'd6;
  localparam logic [3:0] ST_FUN       = 4'd7;
  localparam logic [3:0] ST_ALU_ISSUE = 4'd8;
  localparam logic [3:0] ST_ALU_WAIT  = 4'd9;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  // States in which silence on the line is bounded by the timeout.
  function automatic logic is_timed_state(input logic [3:0] st);
    case (st)
      ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_OP_A,
      ST_OP_B, ST_FUN, ST_ALU_WAIT: is_timed_state = 1'b1;
      default:                      is_timed_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rx_cmd_seq_sat_timer.sv
// Saturating idle-cycle timer; o_tc marks the edge on which the count
// reaches LIMIT so the owner can act on that same edge.
module sat_timer #(
  parameter int LIMIT = 65535,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Count enabled cycles from zero, holding at LIMIT
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt < CNT_W'(LIMIT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = i_en && (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/rx_cmd_seq.sv
// UART command sequencer: turns received frames into register-file writes,
// reads and ALU operations. Every output comes straight from a register.
module rx_cmd_seq
  import rx_cmd_seq_pkg::*;
#(
  parameter int width     = 8,
  parameter int addr_w    = 4,
  parameter int TO_CYCLES = 65535,
  parameter int GUARD_CYC = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [width-1:0]  Rx_Data,
  input  logic              Rx_Data_valid,
  input  logic              Busy,
  input  logic              ALU_out_valid,
  output logic              Wr_En,
  output logic              Rd_En,
  output logic [addr_w-1:0] Address,
  output logic [width-1:0]  WrData,
  output logic              ALU_EN,
  output logic [3:0]        ALU_FUN,
  output logic              Gate_EN,
  output logic              Cmd_Err
);

  localparam int GW = (GUARD_CYC < 1) ? 1 : $clog2(GUARD_CYC + 1);

  logic [3:0]        r_state, w_state;
  logic [addr_w-1:0] r_address, w_address;
  logic [width-1:0]  r_wrdata, w_wrdata;
  logic [3:0]        r_alu_fun, w_alu_fun;
  logic              r_gate_en, w_gate_en;
  logic              r_wr_en, w_wr_en, r_rd_en, w_rd_en;
  logic              r_alu_en, w_alu_en, r_cmd_err, w_cmd_err;
  logic [GW-1:0]     r_guard, w_guard;
  logic              w_accept, w_tc, w_can_issue, w_to_load, w_to_en;
  logic [7:0]        w_byte;

  assign w_byte      = Rx_Data[7:0];
  assign w_can_issue = !Busy && (r_guard == '0);
  assign w_to_en     = is_timed_state(r_state);
  assign w_to_load   = w_accept || (w_state != r_state);

  sat_timer #(.LIMIT(TO_CYCLES)) u_timeout (
    .i_clk  (CLK),
    .i_rst  (Reset),
    .i_load (w_to_load),
    .i_en   (w_to_en),
    .o_tc   (w_tc)
  );

  // Frame decode: next state and next register values
  always_comb begin
    w_state   = r_state;
    w_address = r_address;
    w_wrdata  = r_wrdata;
    w_alu_fun = r_alu_fun;
    w_gate_en = r_gate_en;
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_alu_en  = 1'b0;
    w_cmd_err = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Rx_Data_valid) begin
          w_accept = 1'b1;
          case (w_byte)
            OPC_WR:  w_state = ST_WR_ADDR;
            OPC_RD:  w_state = ST_RD_ADDR;
            OPC_ALU: w_state = ST_OP_A;
            OPC_FUN: w_state = ST_FUN;
            default: w_cmd_err = 1'b1;
          endcase
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_OP_A, ST_OP_B, ST_FUN: begin
        // A byte arriving on the expiry cycle still counts as in time.
        if (Rx_Data_valid) begin
          w_accept = 1'b1;
          case (r_state)
            ST_WR_ADDR: begin
              w_address = Rx_Data[addr_w-1:0];
              w_state   = ST_WR_DATA;
            end
            ST_RD_ADDR: begin
              w_address = Rx_Data[addr_w-1:0];
              w_state   = ST_RD_ISSUE;
            end
            ST_WR_DATA: begin
              w_wr_en  = 1'b1;
              w_wrdata = Rx_Data;
              w_state  = ST_IDLE;
            end
            ST_OP_A: begin
              w_wr_en   = 1'b1;
              w_address = addr_w'(OPA_ADDR);
              w_wrdata  = Rx_Data;
              w_state   = ST_OP_B;
            end
            ST_OP_B: begin
              w_wr_en   = 1'b1;
              w_address = addr_w'(OPB_ADDR);
              w_wrdata  = Rx_Data;
              w_state   = ST_FUN;
            end
            ST_FUN: begin
              w_alu_fun = Rx_Data[3:0];
              w_gate_en = 1'b1;
              w_state   = ST_ALU_ISSUE;
            end
            default: w_state = ST_IDLE;
          endcase
        end else if (w_tc) begin
          w_cmd_err = 1'b1;
          w_gate_en = 1'b0;
          w_state   = ST_IDLE;
        end else begin
          w_state = r_state;
        end
      end
      ST_RD_ISSUE, ST_ALU_ISSUE: begin
        w_cmd_err = Rx_Data_valid;
        if (w_can_issue) begin
          if (r_state == ST_RD_ISSUE) begin
            w_rd_en = 1'b1;
            w_state = ST_IDLE;
          end else begin
            w_alu_en = 1'b1;
            w_state  = ST_ALU_WAIT;
          end
        end else begin
          w_state = r_state;
        end
      end
      ST_ALU_WAIT: begin
        w_cmd_err = Rx_Data_valid;
        if (ALU_out_valid) begin
          w_gate_en = 1'b0;
          w_state   = ST_IDLE;
        end else if (w_tc) begin
          w_cmd_err = 1'b1;
          w_gate_en = 1'b0;
          w_state   = ST_IDLE;
        end else begin
          w_state = ST_ALU_WAIT;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // Guard: reload on each issue so Busy has time to rise before the next one
  always_comb begin
    if (w_rd_en || w_alu_en) begin
      w_guard = GW'(GUARD_CYC);
    end else if (r_guard != '0) begin
      w_guard = r_guard - GW'(1);
    end else begin
      w_guard = '0;
    end
  end

  // State, guard and output registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_address <= '0;
      r_wrdata  <= '0;
      r_alu_fun <= 4'd0;
      r_gate_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_cmd_err <= 1'b0;
      r_guard   <= '0;
    end else begin
      r_state   <= w_state;
      r_address <= w_address;
      r_wrdata  <= w_wrdata;
      r_alu_fun <= w_alu_fun;
      r_gate_en <= w_gate_en;
      r_wr_en   <= w_wr_en;
      r_rd_en   <= w_rd_en;
      r_alu_en  <= w_alu_en;
      r_cmd_err <= w_cmd_err;
      r_guard   <= w_guard;
    end
  end

  assign Wr_En   = r_wr_en;
  assign Rd_En   = r_rd_en;
  assign Address = r_address;
  assign WrData  = r_wrdata;
  assign ALU_EN  = r_alu_en;
  assign ALU_FUN = r_alu_fun;
  assign Gate_EN = r_gate_en;
  assign Cmd_Err = r_cmd_err;

endmodule

// File: tb/tb_rx_cmd_seq.sv
// Bench for rx_cmd_seq: a frame-level reference model checked every cycle,
// plus directed frames with hand-computed expectations.
module tb_rx_cmd_seq;

  localparam int TO = 20;
  localparam int GC = 6;
  localparam int PH_COLLECT = 0, PH_RD = 1, PH_ALU = 2, PH_WAIT = 3;

  logic       clk = 1'b0;
  logic       rst, rx_valid, busy, alu_v;
  logic [7:0] rx_data;
  logic       wr_en, rd_en, alu_en, gate_en, cmd_err;
  logic [3:0] address, alu_fun;
  logic [7:0] wr_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  rx_cmd_seq #(.width(8), .addr_w(4), .TO_CYCLES(TO), .GUARD_CYC(GC)) dut (
    .CLK(clk), .Reset(rst), .Rx_Data(rx_data), .Rx_Data_valid(rx_valid),
    .Busy(busy), .ALU_out_valid(alu_v), .Wr_En(wr_en), .Rd_En(rd_en),
    .Address(address), .WrData(wr_data), .ALU_EN(alu_en), .ALU_FUN(alu_fun),
    .Gate_EN(gate_en), .Cmd_Err(cmd_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: collects frame bytes, acts when a frame is complete
  logic       m_started = 1'b0;
  logic [7:0] m_buf[$];
  int         m_phase, m_idle, m_guard, m_n;
  logic       m_issue;
  logic       e_wr, e_rd, e_alu, e_err, e_gate;
  logic [3:0] e_addr, e_fun;
  logic [7:0] e_data;

  initial begin
    m_phase = PH_COLLECT; m_idle = 0; m_guard = 0;
    forever begin
      @(posedge clk);
      m_started = 1'b1;
      e_wr = 1'b0; e_rd = 1'b0; e_alu = 1'b0; e_err = 1'b0; m_issue = 1'b0;
      if (rst) begin
        m_buf.delete(); m_phase = PH_COLLECT; m_idle = 0; m_guard = 0;
        e_gate = 1'b0; e_addr = 4'd0; e_fun = 4'd0; e_data = 8'd0;
      end else begin
        case (m_phase)
          PH_COLLECT: begin
            if (rx_valid) begin
              m_idle = 0;
              if (m_buf.size() == 0) begin
                if (rx_data inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) m_buf.push_back(rx_data);
                else e_err = 1'b1;
              end else begin
                m_buf.push_back(rx_data);
                m_n = m_buf.size();
                case (m_buf[0])
                  8'hAA: if (m_n == 2) e_addr = rx_data[3:0];
                         else begin e_wr = 1'b1; e_data = rx_data; m_buf.delete(); end
                  8'hBB: begin e_addr = rx_data[3:0]; m_phase = PH_RD; m_buf.delete(); end
                  8'hCC: if (m_n == 4) begin
                           e_fun = rx_data[3:0]; e_gate = 1'b1; m_phase = PH_ALU; m_buf.delete();
                         end else begin
                           e_wr = 1'b1; e_addr = (m_n == 2) ? 4'd0 : 4'd1; e_data = rx_data;
                         end
                  default: begin e_fun = rx_data[3:0]; e_gate = 1'b1; m_phase = PH_ALU; m_buf.delete(); end
                endcase
              end
            end else if (m_buf.size() != 0) begin
              m_idle++;
              if (m_idle == TO) begin
                e_err = 1'b1; e_gate = 1'b0; m_buf.delete(); m_idle = 0;
              end
            end
          end
          PH_RD, PH_ALU: begin
            if (rx_valid) e_err = 1'b1;
            if (!busy && m_guard == 0) begin
              m_issue = 1'b1;
              if (m_phase == PH_RD) begin e_rd = 1'b1; m_phase = PH_COLLECT; end
              else begin e_alu = 1'b1; m_phase = PH_WAIT; m_idle = 0; end
            end
          end
          default: begin
            if (rx_valid) e_err = 1'b1;
            if (alu_v) begin
              e_gate = 1'b0; m_phase = PH_COLLECT;
            end else begin
              m_idle++;
              if (m_idle == TO) begin e_err = 1'b1; e_gate = 1'b0; m_phase = PH_COLLECT; end
            end
          end
        endcase
        if (m_issue) m_guard = GC;
        else if (m_guard > 0) m_guard--;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (m_started) begin
      n_tests++;
      if ({wr_en, rd_en, alu_en, cmd_err, gate_en, address, wr_data, alu_fun} !==
          {e_wr, e_rd, e_alu, e_err, e_gate, e_addr, e_data, e_fun}) begin
        n_fail++;
        $display("FAIL cycle_compare @%0d: got wr=%b rd=%b alu=%b err=%b gate=%b addr=%h data=%h fun=%h, expected wr=%b rd=%b alu=%b err=%b gate=%b addr=%h data=%h fun=%h",
                 cyc, wr_en, rd_en, alu_en, cmd_err, gate_en, address, wr_data, alu_fun,
                 e_wr, e_rd, e_alu, e_err, e_gate, e_addr, e_data, e_fun);
      end
    end
  end

  // Pulse log for directed checks
  int n_wr, n_rd, n_alu, n_err, rd_addr, alu_fn, rd_cyc, alu_cyc, err_cyc;
  int wr_addr_log[8];
  int wr_data_log[8];

  initial forever begin
    @(negedge clk);
    if (wr_en) begin
      if (n_wr < 8) begin wr_addr_log[n_wr] = address; wr_data_log[n_wr] = wr_data; end
      n_wr++;
    end
    if (rd_en)   begin n_rd++;  rd_addr = address; rd_cyc = cyc; end
    if (alu_en)  begin n_alu++; alu_fn = alu_fun;  alu_cyc = cyc; end
    if (cmd_err) begin n_err++; err_cyc = cyc; end
  end

  task automatic clear_log();
    n_wr = 0; n_rd = 0; n_alu = 0; n_err = 0;
    rd_addr = -1; alu_fn = -1; rd_cyc = -1; alu_cyc = -1; err_cyc = -1;
    for (int i = 0; i < 8; i++) begin wr_addr_log[i] = -1; wr_data_log[i] = -1; end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc_in(input logic v, input logic [7:0] d, input logic av);
    @(negedge clk);
    rx_valid = v; rx_data = d; alu_v = av;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_in(1'b0, 8'h00, 1'b0);
    #1;
  endtask

  int t_acc;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; busy = 1'b0; alu_v = 1'b0;
    clear_log();
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", int'({wr_en, rd_en, alu_en, cmd_err, gate_en, address, wr_data, alu_fun}), 0);
    rst = 1'b0;

    // RF write
    clear_log();
    cyc_in(1'b1, 8'hAA, 1'b0); cyc_in(1'b1, 8'h05, 1'b0); cyc_in(1'b1, 8'h3C, 1'b0); idle(3);
    check("wr_count", n_wr, 1);
    check("wr_addr", wr_addr_log[0], 5);
    check("wr_data", wr_data_log[0], 8'h3C);
    check("wr_no_err", n_err, 0);
    check("model_wr_addr", int'(e_addr), 5);
    check("model_wr_data", int'(e_data), 8'h3C);

    // Upper address bits ignored
    clear_log();
    cyc_in(1'b1, 8'hAA, 1'b0); cyc_in(1'b1, 8'hF9, 1'b0); cyc_in(1'b1, 8'h77, 1'b0); idle(3);
    check("wr_addr_trunc", wr_addr_log[0], 9);
    check("wr_data_trunc", wr_data_log[0], 8'h77);

    // RF read held off by Busy
    clear_log();
    busy = 1'b1;
    cyc_in(1'b1, 8'hBB, 1'b0); cyc_in(1'b1, 8'h07, 1'b0); idle(10);
    check("rd_blocked_by_busy", n_rd, 0);
    busy = 1'b0;
    idle(3);
    check("rd_count", n_rd, 1);
    check("rd_addr", rd_addr, 7);

    // ALU with operands
    clear_log();
    cyc_in(1'b1, 8'hCC, 1'b0); cyc_in(1'b1, 8'h10, 1'b0);
    cyc_in(1'b1, 8'h20, 1'b0); cyc_in(1'b1, 8'h01, 1'b0); idle(3);
    check("alu_wr_count", n_wr, 2);
    check("alu_opa_addr", wr_addr_log[0], 0);
    check("alu_opa_data", wr_data_log[0], 8'h10);
    check("alu_opb_addr", wr_addr_log[1], 1);
    check("alu_opb_data", wr_data_log[1], 8'h20);
    check("alu_en_count", n_alu, 1);
    check("alu_fun", alu_fn, 1);
    check("gate_on", int'(gate_en), 1);
    check("model_gate_on", int'(e_gate), 1);
    cyc_in(1'b0, 8'h00, 1'b1); idle(2);
    check("gate_off", int'(gate_en), 0);
    check("alu_single_pulse", n_alu, 1);

    // Illegal opcode
    clear_log();
    cyc_in(1'b1, 8'h55, 1'b0); idle(2);
    check("bad_op_err", n_err, 1);
    check("bad_op_no_cmd", n_wr + n_rd + n_alu, 0);

    // Timeout mid-frame, then a normal read
    clear_log();
    cyc_in(1'b1, 8'hAA, 1'b0); cyc_in(1'b1, 8'h03, 1'b0);
    t_acc = cyc + 1;
    idle(25);
    check("to_err_count", n_err, 1);
    check("to_err_latency", err_cyc - t_acc, TO);
    check("to_no_wr", n_wr, 0);
    cyc_in(1'b1, 8'hBB, 1'b0); cyc_in(1'b1, 8'h03, 1'b0); idle(3);
    check("after_to_rd", n_rd, 1);
    check("after_to_rd_addr", rd_addr, 3);

    // Byte on the expiry cycle wins
    clear_log();
    cyc_in(1'b1, 8'hAA, 1'b0); cyc_in(1'b1, 8'h04, 1'b0); idle(TO - 1);
    cyc_in(1'b1, 8'h66, 1'b0); idle(3);
    check("edge_wr_count", n_wr, 1);
    check("edge_wr_addr", wr_addr_log[0], 4);
    check("edge_wr_data", wr_data_log[0], 8'h66);
    check("edge_no_err", n_err, 0);

    // ALU_WAIT timeout
    clear_log();
    cyc_in(1'b1, 8'hDD, 1'b0); cyc_in(1'b1, 8'h03, 1'b0); idle(TO + 5);
    check("wait_to_alu", n_alu, 1);
    check("wait_to_fun", alu_fn, 3);
    check("wait_to_err", n_err, 1);
    check("wait_to_gate", int'(gate_en), 0);

    // Byte dropped while waiting for the ALU
    clear_log();
    cyc_in(1'b1, 8'hDD, 1'b0); cyc_in(1'b1, 8'h01, 1'b0); idle(2);
    cyc_in(1'b1, 8'hAA, 1'b0); idle(1);
    check("drop_err", n_err, 1);
    check("drop_gate_held", int'(gate_en), 1);
    cyc_in(1'b0, 8'h00, 1'b1); idle(2);
    check("drop_gate_off", int'(gate_en), 0);
    check("drop_no_wr", n_wr, 0);

    // Guard spacing between an ALU issue and the next read
    clear_log();
    cyc_in(1'b1, 8'hDD, 1'b0); cyc_in(1'b1, 8'h01, 1'b0); idle(1);
    cyc_in(1'b0, 8'h00, 1'b1);
    cyc_in(1'b1, 8'hBB, 1'b0); cyc_in(1'b1, 8'h05, 1'b0); idle(8);
    check("guard_rd_count", n_rd, 1);
    check("guard_rd_addr", rd_addr, 5);
    check("guard_spacing", rd_cyc - alu_cyc, GC + 1);

    // Reset mid-frame, then a no-operand ALU frame
    cyc_in(1'b1, 8'hCC, 1'b0); cyc_in(1'b1, 8'h10, 1'b0);
    @(negedge clk); rx_valid = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    check("midframe_reset_outputs", int'({wr_en, rd_en, alu_en, cmd_err, gate_en, address, wr_data, alu_fun}), 0);
    rst = 1'b0;
    clear_log();
    cyc_in(1'b1, 8'hDD, 1'b0); cyc_in(1'b1, 8'h02, 1'b0); idle(4);
    check("post_reset_alu", n_alu, 1);
    check("post_reset_fun", alu_fn, 2);
    check("post_reset_no_wr", n_wr, 0);
    check("post_reset_no_err", n_err, 0);
    check("model_post_reset_fun", int'(e_fun), 2);
    cyc_in(1'b0, 8'h00, 1'b1); idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
